aes_decryption: RTL and testbench



---
 rtl/aes_decryption.sv | 214 +++++++++++++++++++++
 tb/tb_aes_decryption.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/aes_decryption.sv
// Iterative AES-128 inverse cipher: forward key expansion to K10, then one
// decryption round per clock while the key register walks back to K0.
module aes_decryption (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] cipher_text,
  input  logic [127:0] key,
  output logic [127:0] plain_text,
  output logic         busy,
  output logic         done
);

  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] EXPAND = 2'd1;
  localparam logic [1:0] ADD0   = 2'd2;
  localparam logic [1:0] ROUND  = 2'd3;

  logic [1:0]       fsm_q, fsm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [127:0]     state_q, state_d;
  logic [127:0]     key_q, key_d;
  logic [127:0]     pt_d;
  logic             busy_d, done_d;

  // GF(2^8) arithmetic, reduction polynomial 0x11b
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse; 0 maps to 0
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v;
    v = ginv(x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
             ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] t;
    t = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return ginv(t);
  endfunction

  function automatic logic [7:0] rcon(input logic [CNT_W-1:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    logic [31:0] r;
    r = {w[23:0], w[31:24]};
    return {sbox(r[31:24]), sbox(r[23:16]), sbox(r[15:8]), sbox(r[7:0])};
  endfunction

  // InvShiftRows, InvSubBytes, AddRoundKey, then optional InvMixColumns
  function automatic logic [127:0] inv_round(input logic [127:0] s,
                                             input logic [127:0] rk,
                                             input logic         mix);
    logic [127:0] t;
    logic [127:0] m;
    logic [7:0]   a0, a1, a2, a3;
    int           src;
    for (int n = 0; n < 16; n++) begin
      src = (n % 4) + 4 * (((n / 4) + 4 - (n % 4)) % 4);
      t[127-8*n -: 8] = inv_sbox(s[127-8*src -: 8]);
    end
    t = t ^ rk;
    m = t;
    if (mix) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[127-32*c -: 8];
        a1 = t[119-32*c -: 8];
        a2 = t[111-32*c -: 8];
        a3 = t[103-32*c -: 8];
        m[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
        m[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
        m[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
        m[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
    end
    return m;
  endfunction

  // Key-schedule datapath: the four forward S-boxes are shared by both directions
  logic [31:0]      w0, w1, w2, w3;
  logic [31:0]      sw_in, sw_out, rcon_word;
  logic [CNT_W-1:0] rcon_idx;
  logic [127:0]     key_fwd, key_bwd;
  logic [31:0]      fw0, fw1, fw2, bw3, bw2, bw1;

  always_comb begin
    w0        = key_q[127:96];
    w1        = key_q[95:64];
    w2        = key_q[63:32];
    w3        = key_q[31:0];
    rcon_idx  = (fsm_q == ADD0) ? CNT_W'(10) : cnt_q;
    rcon_word = {rcon(rcon_idx), 24'h000000};
    sw_in     = (fsm_q == EXPAND) ? w3 : (w3 ^ w2);
    sw_out    = sub_rot_word(sw_in);
    fw0       = w0 ^ sw_out ^ rcon_word;
    fw1       = w1 ^ fw0;
    fw2       = w2 ^ fw1;
    key_fwd   = {fw0, fw1, fw2, w3 ^ fw2};
    bw3       = w3 ^ w2;
    bw2       = w2 ^ w1;
    bw1       = w1 ^ w0;
    key_bwd   = {w0 ^ sw_out ^ rcon_word, bw1, bw2, bw3};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q      <= IDLE;
      cnt_q      <= '0;
      state_q    <= '0;
      key_q      <= '0;
      plain_text <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      key_q      <= key_d;
      plain_text <= pt_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    key_d   = key_q;
    pt_d    = plain_text;
    busy_d  = busy;
    done_d  = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (start) begin
          state_d = cipher_text;
          key_d   = key;
          cnt_d   = CNT_W'(1);
          busy_d  = 1'b1;
          fsm_d   = EXPAND;
        end
      end
      EXPAND: begin
        key_d = key_fwd;
        cnt_d = CNT_W'(cnt_q + CNT_W'(1));
        if (cnt_q == CNT_W'(10)) fsm_d = ADD0;
      end
      ADD0: begin
        state_d = state_q ^ key_q;
        key_d   = key_bwd;
        cnt_d   = CNT_W'(9);
        fsm_d   = ROUND;
      end
      ROUND: begin
        state_d = inv_round(state_q, key_q, cnt_q != '0);
        if (cnt_q == '0) begin
          pt_d   = inv_round(state_q, key_q, 1'b0);
          done_d = 1'b1;
          busy_d = 1'b0;
          fsm_d  = IDLE;
        end else begin
          key_d = key_bwd;
          cnt_d = CNT_W'(cnt_q - CNT_W'(1));
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_decryption.sv
// Directed bench for aes_decryption: FIPS-197 vectors, latency, ignore-while-busy,
// back-to-back throughput and mid-operation reset.
module tb_aes_decryption;

  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] Z_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] cipher_text;
  logic [127:0] key;
  logic [127:0] plain_text;
  logic         busy;
  logic         done;

  int n_tests = 0;
  int n_fail  = 0;

  aes_decryption dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cipher_text (cipher_text),
    .key         (key),
    .plain_text  (plain_text),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until done is seen; 40 means it never came
  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!done && cyc < 40);
  endtask

  task automatic do_op(input string tag, input logic [127:0] ct, input logic [127:0] k,
                       input logic [127:0] pt_exp);
    int cyc;
    cipher_text = ct;
    key         = k;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    cipher_text = ~ct;
    key         = ~k;
    check_eq({tag, "_busy_after_accept"}, 128'(busy), 128'(1));
    wait_done(cyc);
    check_eq({tag, "_latency"}, 128'(cyc), 128'(21));
    check_eq({tag, "_pt"}, plain_text, pt_exp);
    check_eq({tag, "_busy_at_done"}, 128'(busy), 128'(0));
  endtask

  initial begin
    int cyc;
    logic saw_done;
    rst_n       = 1'b0;
    start       = 1'b0;
    cipher_text = '0;
    key         = '0;
    tick();
    tick();
    check_eq("rst_pt", plain_text, '0);
    check_eq("rst_busy", 128'(busy), 128'(0));
    check_eq("rst_done", 128'(done), 128'(0));
    rst_n = 1'b1;
    tick();

    do_op("appB", B_CT, B_KEY, B_PT);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("idle_done", 128'(done), 128'(0));
      check_eq("idle_pt_hold", plain_text, B_PT);
    end

    do_op("appC1", C_CT, C_KEY, C_PT);
    do_op("zero_key", Z_CT, '0, '0);

    // start held high with inputs changed mid-operation
    cipher_text = B_CT;
    key         = B_KEY;
    start       = 1'b1;
    tick();
    cipher_text = C_CT;
    key         = C_KEY;
    wait_done(cyc);
    check_eq("b2b_first_latency", 128'(cyc), 128'(21));
    check_eq("b2b_first_pt", plain_text, B_PT);
    wait_done(cyc);
    start = 1'b0;
    check_eq("b2b_second_gap", 128'(cyc), 128'(22));
    check_eq("b2b_second_pt", plain_text, C_PT);

    // reset during the 10th cycle of an operation
    cipher_text = B_CT;
    key         = B_KEY;
    start       = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    rst_n = 1'b0;
    tick();
    check_eq("midrst_pt", plain_text, '0);
    check_eq("midrst_busy", 128'(busy), 128'(0));
    check_eq("midrst_done", 128'(done), 128'(0));
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    check_eq("midrst_no_done", 128'(saw_done), 128'(0));
    do_op("after_rst", B_CT, B_KEY, B_PT);

    // start during reset is dropped
    rst_n = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    check_eq("start_in_rst_busy", 128'(busy), 128'(0));
    check_eq("start_in_rst_pt", plain_text, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
